// File: rtl/mnist_img_seq_ctrl.sv
// rtl/mnist_img_seq_ctrl.sv - image fetch/evaluate sequencer for the MNIST classifier
// Optional macro MNIST_REQ_QUEUE_EN: one-entry pending request captured while busy.
module mnist_img_seq_ctrl #(
  parameter int NUM_IMG   = 1000,
  parameter int ADDR_W    = 11,
  parameter int IDX_W     = 10,
  parameter int HALF_W    = 3136,
  parameter int RD_LAT    = 2,
  parameter int NTK_LAT   = 4,
  parameter int NUM_CLASS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_next,
  input  logic                 req_prev,
  output logic [ADDR_W-1:0]    bram_addr,
  input  logic [HALF_W-1:0]    bram_rdata,
  output logic                 buf_wr_lo,
  output logic                 buf_wr_hi,
  output logic                 ntk_start,
  input  logic [NUM_CLASS-1:0] ntk_out,
  output logic [IDX_W-1:0]     img_idx,
  output logic [3:0]           digit,
  output logic                 result_valid,
  output logic                 result_err,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, FETCH, EVAL} state_t;

  state_t                   state, state_d;
  logic [RD_LAT-1:0][1:0]   tag_sr;
  logic [1:0]               tag_push;
  logic [7:0]               cnt;
  logic                     eff_next, eff_prev;
  logic                     step_fwd, step_bwd;
  logic [IDX_W-1:0]         idx_d;
  logic                     eval_done;
  logic [7:0]               ones;
  logic [3:0]               hot;
  logic                     unused_rdata;

  // Pixel data goes straight from BRAM to the buffer; only the strobes come from here.
  assign unused_rdata = ^bram_rdata;

`ifdef MNIST_REQ_QUEUE_EN
  logic pend_valid, pend_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_fwd   <= 1'b0;
    end else if (!busy) begin
      pend_valid <= 1'b0;
    end else if (!pend_valid && (req_next ^ req_prev)) begin
      pend_valid <= 1'b1;
      pend_fwd   <= req_next;
    end
  end

  assign eff_next = pend_valid ? pend_fwd  : req_next;
  assign eff_prev = pend_valid ? !pend_fwd : req_prev;
`else
  assign eff_next = req_next;
  assign eff_prev = req_prev;
`endif

  assign buf_wr_lo = tag_sr[RD_LAT-1][0];
  assign buf_wr_hi = tag_sr[RD_LAT-1][1];
  assign eval_done = (state == EVAL) && (cnt == 8'(NTK_LAT));

  always_comb begin
    state_d  = state;
    step_fwd = 1'b0;
    step_bwd = 1'b0;
    tag_push = 2'b00;
    case (state)
      IDLE: begin
        if (eff_next && !eff_prev) begin
          step_fwd = 1'b1;
          state_d  = ADDR_LO;
        end else if (eff_prev && !eff_next) begin
          step_bwd = 1'b1;
          state_d  = ADDR_LO;
        end
      end
      ADDR_LO: begin
        tag_push = 2'b01;
        state_d  = ADDR_HI;
      end
      ADDR_HI: begin
        tag_push = 2'b10;
        state_d  = FETCH;
      end
      FETCH:   if (buf_wr_hi) state_d = EVAL;
      EVAL:    if (eval_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d = img_idx;
    if (step_fwd)
      idx_d = (img_idx == IDX_W'(NUM_IMG-1)) ? '0 : img_idx + IDX_W'(1);
    else if (step_bwd)
      idx_d = (img_idx == '0) ? IDX_W'(NUM_IMG-1) : img_idx - IDX_W'(1);
  end

  // One-hot decode: last set bit wins for hot, validity comes from the population count.
  always_comb begin
    ones = 8'd0;
    hot  = 4'hF;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (ntk_out[k]) begin
        ones = ones + 8'd1;
        hot  = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ADDR_LO;
      img_idx      <= '0;
      bram_addr    <= '0;
      tag_sr       <= '0;
      ntk_start    <= 1'b0;
      cnt          <= 8'd0;
      digit        <= 4'hF;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state     <= state_d;
      img_idx   <= idx_d;
      ntk_start <= (state == FETCH) && buf_wr_hi;
      for (int i = RD_LAT-1; i > 0; i--) tag_sr[i] <= tag_sr[i-1];
      tag_sr[0] <= tag_push;
      case (state)
        IDLE: begin
          if (step_fwd || step_bwd) begin
            bram_addr    <= ADDR_W'({idx_d, 1'b0});
            result_valid <= 1'b0;
            busy         <= 1'b1;
          end
        end
        ADDR_LO: bram_addr <= ADDR_W'({img_idx, 1'b1});
        FETCH:   cnt <= 8'd0;
        EVAL: begin
          cnt <= cnt + 8'd1;
          if (eval_done) begin
            result_valid <= 1'b1;
            result_err   <= (ones != 8'd1);
            digit        <= (ones == 8'd1) ? hot : 4'hF;
            busy         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_img_seq_ctrl.sv
// tb/tb_mnist_img_seq_ctrl.sv - scoreboard bench for mnist_img_seq_ctrl
module tb_mnist_img_seq_ctrl;

  localparam int NUM_IMG   = 1000;
  localparam int ADDR_W    = 11;
  localparam int IDX_W     = 10;
  localparam int HALF_W    = 3136;
  localparam int RD_LAT    = 2;
  localparam int NTK_LAT   = 4;
  localparam int NUM_CLASS = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_next = 1'b0;
  logic                 req_prev = 1'b0;
  logic [ADDR_W-1:0]    bram_addr;
  logic [HALF_W-1:0]    bram_rdata;
  logic                 buf_wr_lo, buf_wr_hi, ntk_start;
  logic [NUM_CLASS-1:0] ntk_out = '0;
  logic [IDX_W-1:0]     img_idx;
  logic [3:0]           digit;
  logic                 result_valid, result_err, busy;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [3:0]       digit;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic rv_q   = 1'b0;

  logic [15:0]       lo_v, hi_v, st_v, rv_v, busy_v;
  logic [ADDR_W-1:0] addr_a [16];
  logic [15:0]       bmask;
  int                cur;

  mnist_img_seq_ctrl #(
    .NUM_IMG(NUM_IMG), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .HALF_W(HALF_W),
    .RD_LAT(RD_LAT), .NTK_LAT(NTK_LAT), .NUM_CLASS(NUM_CLASS)
  ) dut (
    .clk(clk), .rst(rst), .req_next(req_next), .req_prev(req_prev),
    .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .buf_wr_lo(buf_wr_lo), .buf_wr_hi(buf_wr_hi), .ntk_start(ntk_start),
    .ntk_out(ntk_out), .img_idx(img_idx), .digit(digit),
    .result_valid(result_valid), .result_err(result_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid && !rv_q) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got idx %0d digit %0h, expected no result", img_idx, digit);
      end else begin
        mon_e = sb.pop_front();
        chk("res_idx", 32'(img_idx), 32'(mon_e.idx));
        chk("res_digit", 32'(digit), 32'(mon_e.digit));
        chk("res_err", 32'(result_err), 32'(mon_e.err));
      end
    end
    rv_q = rst ? 1'b0 : result_valid;
  end

  task automatic push(input int idx, input logic [3:0] d, input logic e);
    exp_t x;
    x.idx = IDX_W'(idx);
    x.digit = d;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic pulse(input logic n, input logic p);
    req_next = n;
    req_prev = p;
    @(posedge clk); #2;
    req_next = 1'b0;
    req_prev = 1'b0;
  endtask

  // Entered at posedge+2 of cycle L; k=1 is cycle L.
  task automatic trace(input int inj_k);
    lo_v = '0; hi_v = '0; st_v = '0; rv_v = '0; busy_v = '0;
    for (int k = 1; k <= 14; k++) begin
      req_next = (k == inj_k);
      @(negedge clk);
      lo_v[k] = buf_wr_lo;
      hi_v[k] = buf_wr_hi;
      st_v[k] = ntk_start;
      rv_v[k] = result_valid;
      busy_v[k] = busy;
      addr_a[k] = bram_addr;
      @(posedge clk); #2;
    end
    req_next = 1'b0;
  endtask

  task automatic check_load(input int idx);
    chk("addr_lo", 32'(addr_a[1]), 32'(2*idx));
    chk("addr_hi", 32'(addr_a[2]), 32'(2*idx+1));
    chk("wr_lo_cycle", 32'(lo_v[10:0]), 32'h008);
    chk("wr_hi_cycle", 32'(hi_v[10:0]), 32'h010);
    chk("start_cycle", 32'(st_v[10:0]), 32'h020);
    chk("rv_cycle", 32'(rv_v[10:1]), 32'h200);
    chk("busy_cycles", 32'(busy_v[10:1]), 32'h1FF);
  endtask

  task automatic load(input logic n, input logic p, input int idx,
                      input logic [NUM_CLASS-1:0] nv, input logic [3:0] d, input logic e);
    ntk_out = nv;
    push(idx, d, e);
    pulse(n, p);
    trace(0);
    check_load(idx);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (busy || sb.size() != 0); i++) begin
      @(posedge clk); #2;
    end
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    bram_rdata = '1;
    ntk_out = 10'b0000001000;
    repeat (2) @(negedge clk);
    chk("rst_idx", 32'(img_idx), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_digit", 32'(digit), 32'hF);
    chk("rst_strobes", 32'({buf_wr_lo, buf_wr_hi, ntk_start}), 32'd0);
    chk("rst_result", 32'({result_valid, result_err}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    @(posedge clk); #2;
    rst = 1'b0;
    push(0, 4'd3, 1'b0);
    trace(0);
    check_load(0);

    load(1'b0, 1'b1, 999, 10'b1000000000, 4'd9, 1'b0);
    load(1'b1, 1'b0, 0,   10'b0000000000, 4'hF, 1'b1);
    load(1'b1, 1'b0, 1,   10'b0000100100, 4'hF, 1'b1);
    load(1'b1, 1'b0, 2,   10'b0000000001, 4'd0, 1'b0);

    pulse(1'b1, 1'b1);
    bmask = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bmask[k] = busy;
    end
    chk("both_req_busy", 32'(bmask), 32'd0);
    chk("both_req_idx", 32'(img_idx), 32'd2);
    chk("both_req_addr", 32'(bram_addr), 32'd5);
    @(posedge clk); #2;

    ntk_out = 10'b0000001000;
    push(3, 4'd3, 1'b0);
`ifdef MNIST_REQ_QUEUE_EN
    push(4, 4'd3, 1'b0);
`endif
    pulse(1'b1, 1'b0);
    trace(7);
    check_load(3);
`ifdef MNIST_REQ_QUEUE_EN
    chk("queued_addr", 32'(addr_a[11]), 32'd8);
    chk("queued_busy", 32'(busy_v[11]), 32'd1);
    drain();
    chk("queued_idx", 32'(img_idx), 32'd4);
    cur = 4;
`else
    chk("dropped_idx", 32'(img_idx), 32'd3);
    chk("dropped_busy", 32'(busy_v[14:11]), 32'd0);
    drain();
    cur = 3;
`endif

    pulse(1'b1, 1'b0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("abort_lo_seen", 32'(buf_wr_lo), 32'd1);
    chk("abort_idx_pre", 32'(img_idx), 32'(cur + 1));
    rst = 1'b1;
    #1;
    chk("abort_strobes", 32'({buf_wr_lo, buf_wr_hi, ntk_start}), 32'd0);
    chk("abort_idx", 32'(img_idx), 32'd0);
    chk("abort_addr", 32'(bram_addr), 32'd0);
    chk("abort_busy_rv", 32'({busy, result_valid}), 32'b10);
    @(posedge clk); #2;
    ntk_out = 10'b0000010000;
    rst = 1'b0;
    push(0, 4'd4, 1'b0);
    trace(0);
    check_load(0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_img_seq_ctrl.md
Name: mnist_img_seq_ctrl

Overview:
- Sequencer between the dual-row image BRAM and the MNIST classifier network.
- On a next/previous request it:
  - steps the image index, with wrap-around;
  - fetches the image's two half-rows from BRAM and strobes them into the 784-byte pixel buffer;
  - pulses the network start/reset, waits the network latency, then latches and decodes the one-hot class output.
- Replaces the ad-hoc button FSM in the board top; the top keeps the pixel buffer and the debouncers.

Parameters:
- NUM_IMG, 1000, number of images stored (two BRAM rows each).
- ADDR_W, 11, BRAM address width.
- IDX_W, 10, image index width; must be >= clog2(NUM_IMG).
- HALF_W, 3136, BRAM row width in bits (392 pixels x 8).
- RD_LAT, 2, BRAM read latency in cycles; legal range 1..4.
- NTK_LAT, 4, cycles from ntk_start to valid ntk_out; legal range 1..255.
- NUM_CLASS, 10, width of the one-hot network output.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_next  in  1  single-cycle pulse: advance one image.
- req_prev  in  1  single-cycle pulse: go back one image.
- bram_addr  out  ADDR_W  registered BRAM read address.
- bram_rdata  in  HALF_W  BRAM read data, valid RD_LAT cycles after its address.
- buf_wr_lo  out  1  pulse: write bram_rdata into pixels 0..391.
- buf_wr_hi  out  1  pulse: write bram_rdata into pixels 392..783.
- ntk_start  out  1  one-cycle pulse to the network rst input.
- ntk_out  in  NUM_CLASS  network one-hot class output.
- img_idx  out  IDX_W  currently selected image.
- digit  out  4  decoded class, 0..9; 4'hF if invalid.
- result_valid  out  1  digit/result_err valid for img_idx.
- result_err  out  1  ntk_out was not exactly one-hot.
- busy  out  1  load/evaluate in progress.

Behaviour:
- Async reset values:
  - img_idx=0, bram_addr=0, digit=4'hF.
  - buf_wr_lo=0, buf_wr_hi=0, ntk_start=0.
  - result_valid=0, result_err=0.
  - busy=1, state=ADDR_LO.
  - Result: image 0 is loaded automatically after reset release.
- States: IDLE, ADDR_LO, ADDR_HI, FETCH, EVAL.
- IDLE (busy=0):
  - req_next: img_idx = (img_idx==NUM_IMG-1) ? 0 : img_idx+1, then go to ADDR_LO.
  - req_prev: img_idx = (img_idx==0) ? NUM_IMG-1 : img_idx-1, then go to ADDR_LO.
  - Both requests in the same cycle: both ignored, stay in IDLE.
- ADDR_LO (cycle L):
  - bram_addr = 2*img_idx; result_valid cleared; busy=1.
  - Next state ADDR_HI.
- ADDR_HI (cycle L+1):
  - bram_addr = 2*img_idx+1.
  - Next state FETCH.
- FETCH:
  - buf_wr_lo high exactly in cycle L+RD_LAT; buf_wr_hi high exactly in cycle L+RD_LAT+1.
  - Timing is tracked with a 2-bit tag shift register of depth RD_LAT, not assumed from state.
  - Exit to EVAL after buf_wr_hi.
- EVAL:
  - ntk_start high in cycle S = L+RD_LAT+2.
  - An 8-bit counter runs to NTK_LAT.
  - ntk_out is sampled in cycle S+NTK_LAT.
  - digit/result_err/result_valid update in cycle S+NTK_LAT+1; busy=0 in the same cycle; state returns to IDLE.
- Decode of ntk_out:
  - Exactly one bit k set: digit=k, result_err=0.
  - Otherwise (zero bits or more than one bit set): digit=4'hF, result_err=1.
- bram_addr holds its last value in IDLE.
- Requests while busy=1 are dropped, unless REQ_QUEUE_EN is defined.
- Reset mid-operation:
  - All outputs return to their reset values immediately, including any in-flight strobes.
  - Sequence restarts at image 0.
- End-to-end latency at default parameters: request in cycle R, then ADDR_LO in R+1, ntk_start in R+5, result_valid in R+10.

Optional Feature:
- Macro: MNIST_REQ_QUEUE_EN.
- Defined:
  - A one-entry pending register (direction + valid) captures the first req_next or req_prev seen while busy=1.
  - A simultaneous next+prev pair is not captured.
  - Later requests while the entry is full are dropped.
  - On the cycle busy would fall, the pending request is applied as if issued in IDLE: index steps and the state enters ADDR_LO on the next cycle.
  - result_valid pulses high for one cycle for the intermediate image.
  - The pending entry is cleared by rst.
- Undefined: no pending register; all requests while busy are ignored.

Test Plan:
- Reset release, ntk_out=10'b0000001000:
  - bram_addr=0 in cycle 1, then 1.
  - buf_wr_lo in cycle 3, buf_wr_hi in cycle 4, ntk_start in cycle 5.
  - result_valid in cycle 10 with digit=3, img_idx=0.
- Wrap-around:
  - In IDLE with img_idx=999, req_next gives img_idx=0 and bram_addr 0 then 1.
  - From img_idx=0, req_prev gives img_idx=999 and bram_addr 1998 then 1999.
- Invalid one-hot:
  - ntk_out=10'b0000000000 gives digit=F, result_err=1.
  - ntk_out=10'b0000100100 gives digit=F, result_err=1.
  - ntk_out=10'b1000000000 gives digit=9, result_err=0.
- Simultaneous req_next+req_prev in IDLE: no state change, busy stays 0, img_idx unchanged.
- req_next during EVAL:
  - Macro undefined: request dropped, img_idx unchanged after completion.
  - Macro defined: second load starts the cycle after busy falls, ending with img_idx+2.
- rst asserted during FETCH, before buf_wr_hi: strobes go low immediately, img_idx=0, and the full load of image 0 repeats after release.
